audio_ns_sched: RTL

//  Sample scheduler in front of fix_audio_ns. Paces the toggle req/ack handshake from the

---
 rtl/audio_ns_pkg.sv | 34 +++
 rtl/audio_ns_sync_edge.sv | 35 +++
 rtl/audio_ns_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/audio_ns_pkg.sv
// Shared types and constants for the fix_audio_ns sample scheduler:
// FSM state encoding, conf field layout and a conf packing helper.
package audio_ns_pkg;

    localparam int DW_DEF = 16;
    localparam int CONFW  = 2*DW_DEF + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        WAIT = 2'd2,
        REQ  = 2'd3
    } state_t;

    // conf = {vol, kal_pnc, sel_lpf, sel_hpf}
    localparam int SEL_HPF_LSB = 0;
    localparam int SEL_HPF_W   = 2;
    localparam int SEL_LPF_LSB = 2;
    localparam int SEL_LPF_W   = 2;
    localparam int KAL_PNC_LSB = 4;
    localparam int KAL_PNC_W   = DW_DEF;
    localparam int VOL_LSB     = 4 + DW_DEF;
    localparam int VOL_W       = DW_DEF;

    function automatic logic [CONFW-1:0] conf_pack(
        input logic [VOL_W-1:0]     vol,
        input logic [KAL_PNC_W-1:0] kal,
        input logic [SEL_LPF_W-1:0] lpf,
        input logic [SEL_HPF_W-1:0] hpf
    );
        return {vol, kal, lpf, hpf};
    endfunction

endpackage

// File: rtl/audio_ns_sync_edge.sv
// Two-flop synchroniser with a registered copy for edge detection.
// Ports: clk, rst (async high), i_d async input, o_pulse 1-cycle edge strobe
// (rising edge only, or either edge when ANY_EDGE=1).
module audio_ns_sync_edge #(
    parameter bit ANY_EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    if (ANY_EDGE) begin : g_any
        assign o_pulse = r_sync ^ r_prev;
    end else begin : g_rise
        assign o_pulse = r_sync & ~r_prev;
    end

endmodule

// File: rtl/audio_ns_sched.sv
// Sample scheduler in front of fix_audio_ns: one toggle request per lrclk
// frame, conf applied at frame boundaries through an enable-drop window,
// processed samples returned with a 1-cycle strobe, overrun/overflow
// counting and ack timeout recovery.
// Ports: clk/rst, lrclk, in_data, cfg_conf/cfg_wr, run; ns_* to/from
// fix_audio_ns; out_data/out_valid, busy, overrun_cnt, ovf_cnt, tmo_err.
module audio_ns_sched #(
    parameter int DW     = 16,
    parameter int EN_LOW = 5,
    parameter int TMO    = 4095,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lrclk,
    input  logic [DW-1:0]   in_data,
    input  logic [2*DW+3:0] cfg_conf,
    input  logic            cfg_wr,
    input  logic            run,
    output logic            ns_req,
    input  logic            ns_ack,
    input  logic            ns_overflow,
    output logic            ns_enable,
    output logic [2*DW+3:0] ns_conf,
    output logic [DW-1:0]   ns_rx_data,
    input  logic [DW-1:0]   ns_tx_data,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic            busy,
    output logic [CNTW-1:0] overrun_cnt,
    output logic [CNTW-1:0] ovf_cnt,
    output logic            tmo_err
);

    import audio_ns_pkg::*;

    localparam int CW = 2*DW + 4;
    localparam int EW = (EN_LOW < 2) ? 1 : $clog2(EN_LOW);
    localparam int TW = $clog2(TMO + 1);

    state_t          r_state;
    state_t          w_nx;
    logic [EW-1:0]   r_cfg_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_req;
    logic [DW-1:0]   r_rx;
    logic [CW-1:0]   r_conf;
    logic [CW-1:0]   r_shadow;
    logic            r_pending;
    logic [DW-1:0]   r_out;
    logic            r_valid;
    logic [CNTW-1:0] r_ovr;
    logic [CNTW-1:0] r_ovf;
    logic            r_ovf_d;
    logic            r_tmo;

    logic w_fs;
    logic w_ack_ev;
    logic w_cfg_done;
    logic w_start;
    logic w_done;
    logic w_tmo;
    logic w_ovf_rise;

    audio_ns_sync_edge #(.ANY_EDGE(1'b0)) u_lr_sync (
        .clk     (clk),
        .rst     (rst),
        .i_d     (lrclk),
        .o_pulse (w_fs)
    );

    // Reset clears these flops, so an ack landing during reset is lost.
    audio_ns_sync_edge #(.ANY_EDGE(1'b1)) u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .i_d     (ns_ack),
        .o_pulse (w_ack_ev)
    );

    assign w_cfg_done = (r_state == CFG) &&
                        (r_cfg_cnt == EW'(EN_LOW - 1));
    assign w_start    = (r_state == WAIT) && w_fs &&
                        !r_pending && run;
    assign w_done     = (r_state == REQ) && w_ack_ev;
    assign w_tmo      = (r_state == REQ) && !w_ack_ev &&
                        (r_timer == TW'(TMO - 1));
    assign w_ovf_rise = ns_overflow && !r_ovf_d;

    always_comb begin
        w_nx = r_state;
        unique case (r_state)
            IDLE: if (run) w_nx = CFG;
            CFG:  if (w_cfg_done) w_nx = WAIT;
            WAIT: begin
                if (w_fs && r_pending) w_nx = CFG;
                else if (!run)         w_nx = IDLE;
                else if (w_fs)         w_nx = REQ;
            end
            REQ: begin
                if (w_ack_ev)   w_nx = WAIT;
                else if (w_tmo) w_nx = CFG;
            end
            default: w_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cfg_cnt <= '0;
            r_timer   <= '0;
            r_req     <= 1'b0;
            r_rx      <= '0;
            r_conf    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= '0;
            r_ovf     <= '0;
            r_ovf_d   <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state <= w_nx;

            if (r_state == CFG) begin
                r_cfg_cnt <= r_cfg_cnt + 1'b1;
                r_conf    <= r_shadow;
            end else begin
                r_cfg_cnt <= '0;
            end

            // A write in the exit cycle survives and forces another CFG.
            if (cfg_wr) begin
                r_shadow  <= cfg_conf;
                r_pending <= 1'b1;
            end else if (w_cfg_done) begin
                r_pending <= 1'b0;
            end

            if (w_tmo)
                r_tmo <= 1'b1;
            else if (w_cfg_done && r_pending)
                r_tmo <= 1'b0;

            if (w_start)
                r_timer <= '0;
            else if (r_state == REQ)
                r_timer <= r_timer + 1'b1;

            // After a timeout the DUT is re-enabled with ack=0.
            if (w_start) begin
                r_req <= ~r_req;
                r_rx  <= in_data;
            end else if (w_tmo) begin
                r_req <= 1'b0;
            end

            if (w_done)
                r_out <= ns_tx_data;
            r_valid <= w_done;

            if ((r_state == REQ) && w_fs && (r_ovr != '1))
                r_ovr <= r_ovr + 1'b1;

            r_ovf_d <= ns_overflow;
            if (w_ovf_rise && (r_ovf != '1))
                r_ovf <= r_ovf + 1'b1;
        end
    end

    assign ns_req      = r_req;
    assign ns_enable   = (r_state == WAIT) || (r_state == REQ);
    assign ns_conf     = r_conf;
    assign ns_rx_data  = r_rx;
    assign out_data    = r_out;
    assign out_valid   = r_valid;
    assign busy        = (r_state == REQ);
    assign overrun_cnt = r_ovr;
    assign ovf_cnt     = r_ovf;
    assign tmo_err     = r_tmo;

endmodule
